// File: rtl/loader_pkg.sv
// Shared types and sizes for the boot-time program loader.
// The processor and its program memory take ADDR_W/DATA_W from this package too.
package loader_pkg;
    localparam int ADDR_W    = 12;
    localparam int DATA_W    = 16;
    localparam int HDR_BYTES = 2;

    typedef enum logic [2:0] {
        HDR_HI  = 3'd0,
        HDR_LO  = 3'd1,
        DATA_HI = 3'd2,
        DATA_LO = 3'd3,
        WRITE   = 3'd4,
        DONE    = 3'd5,
        ERROR   = 3'd6
    } loader_state_t;
endpackage

// File: rtl/byte_pair_assembler.sv
// Joins consecutive bytes into big-endian pairs for both the header and the data words.
// The phase flag marks the second byte of each pair; pair is only meaningful on that transfer.
module byte_pair_assembler
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        byte_in,
    input  logic              shift,
    output logic [DATA_W-1:0] pair,
    output logic              pair_valid
);
    logic [7:0] hi_q;
    logic       phase_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q    <= '0;
            phase_q <= 1'b0;
        end else if (shift) begin
            hi_q    <= byte_in;
            phase_q <= ~phase_q;
        end
    end

    assign pair       = {hi_q, byte_in};
    assign pair_valid = shift && phase_q;
endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed big-endian byte image into program memory from address 0,
// then raises ProcRun; a zero or oversized length halts with LoadError instead.
module program_loader #(
    parameter int ADDR_W    = loader_pkg::ADDR_W,
    parameter int DATA_W    = loader_pkg::DATA_W,
    parameter int MAX_WORDS = 2 ** ADDR_W
) (
    input  logic                      Clock,
    input  logic                      nReset,
    input  logic [7:0]                ByteIn,
    input  logic                      ByteValid,
    output logic                      ByteReady,
    output logic [ADDR_W-1:0]         MemAddr,
    output logic [DATA_W-1:0]         MemData,
    output logic                      MemWrite,
    output logic                      ProcRun,
    output logic                      LoadError,
    output loader_pkg::loader_state_t State
);
    import loader_pkg::*;

    if (DATA_W != 16) begin : g_width_check
        $error("program_loader: DATA_W must be 16 (two bytes per word)");
    end

    localparam logic [DATA_W-1:0] MAX_N = DATA_W'(MAX_WORDS);

    // A byte moves on a rising edge only when ByteValid && ByteReady.
    loader_state_t     state_q;
    logic              xfer;
    logic              pair_valid;
    logic [DATA_W-1:0] pair;
    logic [ADDR_W:0]   word_count;
    logic [ADDR_W:0]   last_idx;

    assign State    = state_q;
    assign xfer     = ByteValid && ByteReady;
    assign last_idx = word_count - (ADDR_W + 1)'(1);

    byte_pair_assembler u_asm (
        .clk        (Clock),
        .rst_n      (nReset),
        .byte_in    (ByteIn),
        .shift      (xfer),
        .pair       (pair),
        .pair_valid (pair_valid)
    );

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q    <= HDR_HI;
            ByteReady  <= 1'b0;
            MemAddr    <= '0;
            MemData    <= '0;
            MemWrite   <= 1'b0;
            ProcRun    <= 1'b0;
            LoadError  <= 1'b0;
            word_count <= '0;
        end else begin
            case (state_q)
                HDR_HI: begin
                    ByteReady <= 1'b1;
                    if (xfer) state_q <= HDR_LO;
                end
                HDR_LO: begin
                    if (pair_valid) begin
                        if (pair == '0 || pair > MAX_N) begin
                            state_q   <= ERROR;
                            ByteReady <= 1'b0;
                            LoadError <= 1'b1;
                        end else begin
                            word_count <= pair[ADDR_W:0];
                            state_q    <= DATA_HI;
                        end
                    end
                end
                DATA_HI: begin
                    if (xfer) begin
                        MemData[DATA_W-1:8] <= ByteIn;
                        state_q             <= DATA_LO;
                    end
                end
                DATA_LO: begin
                    if (pair_valid) begin
                        MemData   <= pair;
                        MemWrite  <= 1'b1;
                        ByteReady <= 1'b0;
                        state_q   <= WRITE;
                    end
                end
                WRITE: begin
                    // N <= MAX_WORDS guarantees the last index fits, so MemAddr never wraps.
                    MemWrite <= 1'b0;
                    if ({1'b0, MemAddr} == last_idx) begin
                        state_q <= DONE;
                        ProcRun <= 1'b1;
                    end else begin
                        MemAddr   <= MemAddr + ADDR_W'(1);
                        ByteReady <= 1'b1;
                        state_q   <= DATA_HI;
                    end
                end
                DONE, ERROR: begin
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a table of whole-image loads plus hand-written
// sequences for stalls, the maximum image, asynchronous reset and post-done input.
module tb_program_loader;
    import loader_pkg::*;

    logic          Clock = 1'b0;
    logic          nReset;
    logic [7:0]    ByteIn;
    logic          ByteValid;
    logic          ByteReady;
    logic [11:0]   MemAddr;
    logic [15:0]   MemData;
    logic          MemWrite;
    logic          ProcRun;
    logic          LoadError;
    loader_state_t State;

    program_loader dut (
        .Clock     (Clock),
        .nReset    (nReset),
        .ByteIn    (ByteIn),
        .ByteValid (ByteValid),
        .ByteReady (ByteReady),
        .MemAddr   (MemAddr),
        .MemData   (MemData),
        .MemWrite  (MemWrite),
        .ProcRun   (ProcRun),
        .LoadError (LoadError),
        .State     (State)
    );

    // ---------------- clock / reset ----------------
    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;
    logic [27:0] exp_q[$];   // {addr, data} of each write the bench expects

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        ByteValid = 1'b0;
        ByteIn    = 8'h00;
        nReset    = 1'b0;
        repeat (2) @(negedge Clock);
        check("rst_ready",  ByteReady, 0);
        check("rst_addr",   MemAddr,   0);
        check("rst_data",   MemData,   0);
        check("rst_write",  MemWrite,  0);
        check("rst_run",    ProcRun,   0);
        check("rst_err",    LoadError, 0);
        check("rst_state",  32'(State), 32'(HDR_HI));
        nReset = 1'b1;
        @(negedge Clock);
        check("post_rst_ready", ByteReady, 1);
        exp_q.delete();
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge; returns at the falling edge after the byte transferred.
    task automatic send_byte(input logic [7:0] b);
        int cnt = 0;
        ByteIn    = b;
        ByteValid = 1'b1;
        while (!ByteReady && cnt < 20) begin
            @(negedge Clock);
            cnt++;
        end
        if (!ByteReady) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=ready_low required=ready_high byte=%h", b);
            ByteValid = 1'b0;
        end else begin
            @(negedge Clock);
            ByteValid = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        ByteValid = 1'b0;
        repeat (n) @(negedge Clock);
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge Clock) begin
        if (nReset && MemWrite) begin
            check("write_ready_low", ByteReady, 0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual=%h:%h required=no_write", MemAddr, MemData);
            end else begin
                check("write_pair", {4'h0, MemAddr, MemData}, {4'h0, exp_q.pop_front()});
            end
        end
    end

    // ---------------- vectors ----------------
    typedef struct {
        logic [15:0] n;
        logic [15:0] words[4];
        logic        err;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] n;
        logic [15:0] w;

        vecs[0] = '{n: 16'd3,    words: '{16'h1234, 16'hABCD, 16'h000F, 16'h0000}, err: 1'b0};
        vecs[1] = '{n: 16'h0000, words: '{16'h0, 16'h0, 16'h0, 16'h0},             err: 1'b1};
        vecs[2] = '{n: 16'h1001, words: '{16'h0, 16'h0, 16'h0, 16'h0},             err: 1'b1};
        vecs[3] = '{n: 16'd1,    words: '{16'h5A5A, 16'h0, 16'h0, 16'h0},          err: 1'b0};
        vecs[4] = '{n: 16'd2,    words: '{16'hFFFF, 16'h0000, 16'h0, 16'h0},       err: 1'b0};

        for (int v = 0; v < 5; v++) begin
            do_reset();
            n = vecs[v].n;
            if (!vecs[v].err)
                for (int i = 0; i < int'(n); i++)
                    exp_q.push_back({12'(i), vecs[v].words[i]});
            send_byte(n[15:8]);
            send_byte(n[7:0]);
            if (vecs[v].err) begin
                check("err_flag",  LoadError, 1);
                check("err_ready", ByteReady, 0);
                check("err_run",   ProcRun,   0);
                check("err_state", 32'(State), 32'(ERROR));
                idle(3);
                check("err_hold_flag",  LoadError, 1);
                check("err_hold_ready", ByteReady, 0);
            end else begin
                for (int i = 0; i < int'(n); i++) begin
                    w = vecs[v].words[i];
                    send_byte(w[15:8]);
                    send_byte(w[7:0]);
                end
                check("last_write_strobe", MemWrite, 1);
                check("run_before_write",  ProcRun,  0);
                @(negedge Clock);
                check("done_run",    ProcRun,   1);
                check("done_write",  MemWrite,  0);
                check("done_ready",  ByteReady, 0);
                check("done_err",    LoadError, 0);
                check("done_addr",   MemAddr,   32'(n - 16'd1));
                check("done_data",   MemData,   vecs[v].words[int'(n) - 1]);
                check("done_q_empty", exp_q.size(), 0);
            end
        end

        // Stalled host: gaps between bytes must hold the state.
        do_reset();
        exp_q.push_back({12'h000, 16'hBEEF});
        send_byte(8'h00); idle(2); check("stall_hdr_lo",  32'(State), 32'(HDR_LO));
        send_byte(8'h01); idle(2); check("stall_data_hi", 32'(State), 32'(DATA_HI));
        send_byte(8'hBE); idle(2); check("stall_data_lo", 32'(State), 32'(DATA_LO));
        check("stall_no_write", MemWrite, 0);
        send_byte(8'hEF);
        @(negedge Clock);
        check("stall_run", ProcRun, 1);
        check("stall_q_empty", exp_q.size(), 0);

        // Post-done: further bytes are ignored.
        for (int i = 0; i < 20; i++) begin
            ByteValid = 1'b1;
            ByteIn    = 8'($urandom_range(0, 255));
            @(negedge Clock);
            check("pd_ready", ByteReady, 0);
            check("pd_addr",  MemAddr,   0);
            check("pd_data",  MemData,   16'hBEEF);
            check("pd_run",   ProcRun,   1);
        end
        ByteValid = 1'b0;

        // Maximum image: 4096 words, last address FFF, no wrap.
        do_reset();
        for (int i = 0; i < 4096; i++) exp_q.push_back({12'(i), 16'(i)});
        send_byte(8'h10);
        send_byte(8'h00);
        check("max_accepted", LoadError, 0);
        for (int i = 0; i < 4096; i++) begin
            w = 16'(i);
            send_byte(w[15:8]);
            send_byte(w[7:0]);
        end
        @(negedge Clock);
        check("max_run",  ProcRun, 1);
        check("max_addr", MemAddr, 12'hFFF);
        check("max_data", MemData, 16'h0FFF);
        check("max_q_empty", exp_q.size(), 0);

        // Asynchronous reset partway through a 4-word image.
        do_reset();
        exp_q.push_back({12'h000, 16'h1111});
        exp_q.push_back({12'h001, 16'h2222});
        send_byte(8'h00); send_byte(8'h04);
        send_byte(8'h11); send_byte(8'h11);
        send_byte(8'h22); send_byte(8'h22);
        @(negedge Clock);
        check("mid_addr_before", MemAddr, 2);
        #2;
        nReset = 1'b0;
        #1;
        check("async_addr",  MemAddr,   0);
        check("async_data",  MemData,   0);
        check("async_ready", ByteReady, 0);
        check("async_write", MemWrite,  0);
        check("async_state", 32'(State), 32'(HDR_HI));
        @(negedge Clock);
        nReset = 1'b1;
        @(negedge Clock);
        check("restart_q_empty", exp_q.size(), 0);
        exp_q.push_back({12'h000, 16'h55AA});
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h55); send_byte(8'hAA);
        @(negedge Clock);
        check("restart_run",  ProcRun, 1);
        check("restart_data", MemData, 16'h55AA);
        check("restart_q_empty2", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
